sbio_req_scheduler: RTL and testbench

SBIO_REQ_SCHEDULER -- requirements
Module: sbio_req_scheduler

---
 rtl/sbio_pkg.sv | 15 +
 rtl/sbio_tag_fifo.sv | 75 +++++++
 rtl/sbio_req_scheduler.sv | 114 +++++++++++
 tb/tb_sbio_req_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sbio_pkg.sv
// Shared defaults for the SBIO request scheduler: pin width, message lengths
// and the payload widths derived from them.
package sbio_pkg;

    localparam int SBIO_IO_BITS           = 2;
    localparam int SBIO_TX_PAYLOAD_CYCLES = 10;
    localparam int SBIO_RX_PAYLOAD_CYCLES = 8;
    localparam int SBIO_TXB               = SBIO_IO_BITS * SBIO_TX_PAYLOAD_CYCLES;
    localparam int SBIO_RXB               = SBIO_IO_BITS * SBIO_RX_PAYLOAD_CYCLES;

    function automatic int sbio_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbio_tag_fifo.sv
// In-order FIFO of requester indices for reads awaiting a response.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sbio_tag_fifo
    import sbio_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int PW   = sbio_clog2_min1(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CNTW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sbio_req_scheduler.sv
// Round-robin scheduler feeding one SBIO transmitter from several requesters,
// routing in-order read responses back to the requester that issued each read.
module sbio_req_scheduler
    import sbio_pkg::*;
#(
    parameter int IO_BITS           = SBIO_IO_BITS,
    parameter int TX_PAYLOAD_CYCLES = SBIO_TX_PAYLOAD_CYCLES,
    parameter int RX_PAYLOAD_CYCLES = SBIO_RX_PAYLOAD_CYCLES,
    parameter int NUM_REQ           = 2,
    parameter int MAX_OUTSTANDING   = 4,
    localparam int TXB = IO_BITS * TX_PAYLOAD_CYCLES,
    localparam int RXB = IO_BITS * RX_PAYLOAD_CYCLES,
    localparam int IDW = sbio_clog2_min1(NUM_REQ),
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_is_read,
    input  logic [NUM_REQ*TXB-1:0] req_payload,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_payload_valid,
    output logic [TXB-1:0]         tx_payload,
    input  logic                   tx_payload_accepted,
    input  logic                   rx_payload_received,
    input  logic [RXB-1:0]         rx_payload,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [RXB-1:0]         resp_payload,
    output logic [CW-1:0]          outstanding,
    output logic                   err_unexpected
);

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [RXB-1:0]     resp_payload_q, resp_payload_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] eligible;
    logic               any_elig;
    logic [IDW-1:0]     winner;
    logic               accept, push, pop;
    logic               fifo_full, fifo_empty;
    logic [IDW-1:0]     head_idx;
    logic [CW-1:0]      fifo_count;

    // Scan from highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [IDW-1:0] idx;
        idx      = '0;
        eligible = req_valid & (~req_is_read | {NUM_REQ{~fifo_full}});
        any_elig = 1'b0;
        winner   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (eligible[idx]) begin
                any_elig = 1'b1;
                winner   = idx;
            end
        end
    end

    assign tx_payload_valid = any_elig && !reset;
    assign tx_payload       = req_payload[winner*TXB +: TXB];
    assign accept           = tx_payload_valid && tx_payload_accepted;
    assign req_ready        = accept ? (NUM_REQ'(1) << winner) : '0;
    assign push             = accept && req_is_read[winner];
    assign pop              = rx_payload_received && !fifo_empty;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
        resp_valid_d   = pop ? (NUM_REQ'(1) << head_idx) : '0;
        resp_payload_d = pop ? rx_payload : resp_payload_q;
        // A read pushed in the same cycle cannot satisfy this response.
        err_d          = err_q | (rx_payload_received && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            resp_valid_q   <= '0;
            resp_payload_q <= '0;
            err_q          <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            resp_valid_q   <= resp_valid_d;
            resp_payload_q <= resp_payload_d;
            err_q          <= err_d;
        end
    end

    sbio_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (winner),
        .pop       (pop),
        .pop_data  (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign outstanding    = fifo_count;
    assign resp_valid     = resp_valid_q;
    assign resp_payload   = resp_payload_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_sbio_req_scheduler.sv
// Directed bench for sbio_req_scheduler: a vector table for arbitration and
// response routing, plus short sequences for back-pressure, wrap and reset.
module tb_sbio_req_scheduler;
    import sbio_pkg::*;

    localparam logic [SBIO_TXB-1:0] P0 = 20'hA0A0A;
    localparam logic [SBIO_TXB-1:0] P1 = 20'h5B5B5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            req_valid;
    logic [1:0]            req_is_read;
    logic [2*SBIO_TXB-1:0] req_payload;
    logic [1:0]            req_ready;
    logic                  tx_payload_valid;
    logic [SBIO_TXB-1:0]   tx_payload;
    logic                  tx_payload_accepted;
    logic                  rx_payload_received;
    logic [SBIO_RXB-1:0]   rx_payload;
    logic [1:0]            resp_valid;
    logic [SBIO_RXB-1:0]   resp_payload;
    logic [2:0]            outstanding;
    logic                  err_unexpected;

    int n_pass  = 0;
    int n_total = 0;
    int step    = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [1:0]  rd;
        logic        acc;
        logic        rx;
        logic [15:0] rxd;
        logic        txv;
        logic [1:0]  rdy;
        logic        chk_txp;
        logic [19:0] txp;
        logic [2:0]  out;
        logic [1:0]  rsp;
        logic [15:0] rp;
        logic        err;
    } vec_t;

    vec_t tbl [17];

    sbio_req_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_is_read         (req_is_read),
        .req_payload         (req_payload),
        .req_ready           (req_ready),
        .tx_payload_valid    (tx_payload_valid),
        .tx_payload          (tx_payload),
        .tx_payload_accepted (tx_payload_accepted),
        .rx_payload_received (rx_payload_received),
        .rx_payload          (rx_payload),
        .resp_valid          (resp_valid),
        .resp_payload        (resp_payload),
        .outstanding         (outstanding),
        .err_unexpected      (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
    endtask

    // Inputs change on the falling edge; combinational outputs are checked
    // before the rising edge, registered outputs 1 time unit after it.
    task automatic apply(input vec_t v);
        step++;
        @(negedge clk);
        reset               = v.rst;
        req_valid           = v.rv;
        req_is_read         = v.rd;
        tx_payload_accepted = v.acc;
        rx_payload_received = v.rx;
        rx_payload          = v.rxd;
        #1;
        chk("tx_payload_valid", step, 32'(tx_payload_valid), 32'(v.txv));
        chk("req_ready", step, 32'(req_ready), 32'(v.rdy));
        if (v.chk_txp) chk("tx_payload", step, 32'(tx_payload), 32'(v.txp));
        @(posedge clk);
        #1;
        chk("outstanding", step, 32'(outstanding), 32'(v.out));
        chk("resp_valid", step, 32'(resp_valid), 32'(v.rsp));
        chk("resp_payload", step, 32'(resp_payload), 32'(v.rp));
        chk("err_unexpected", step, 32'(err_unexpected), 32'(v.err));
    endtask

    task automatic do_reset();
        // Requests and a response pulse are active during reset and must be ignored.
        apply(vec_t'{1, 2'b11, 2'b11, 1, 1, 16'hFFFF, 0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0, 0});
    endtask

    initial begin
        reset               = 1'b1;
        req_valid           = '0;
        req_is_read         = '0;
        req_payload         = {P1, P0};
        tx_payload_accepted = 1'b0;
        rx_payload_received = 1'b0;
        rx_payload          = '0;

        // rst, rv, rd, acc, rx, rxd | txv, rdy, chk_txp, txp | out, rsp, rp, err
        tbl[0]  = '{0, 2'b11, 2'b00, 1, 0, 16'h0,    1, 2'b01, 1, P0,    3'd0, 2'b00, 16'h0,    0};
        tbl[1]  = '{0, 2'b11, 2'b00, 1, 0, 16'h0,    1, 2'b10, 1, P1,    3'd0, 2'b00, 16'h0,    0};
        tbl[2]  = '{0, 2'b11, 2'b00, 1, 0, 16'h0,    1, 2'b01, 1, P0,    3'd0, 2'b00, 16'h0,    0};
        tbl[3]  = '{0, 2'b11, 2'b00, 1, 0, 16'h0,    1, 2'b10, 1, P1,    3'd0, 2'b00, 16'h0,    0};
        tbl[4]  = '{0, 2'b11, 2'b00, 0, 0, 16'h0,    1, 2'b00, 1, P0,    3'd0, 2'b00, 16'h0,    0};
        tbl[5]  = '{0, 2'b00, 2'b00, 1, 0, 16'h0,    0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0,    0};
        tbl[6]  = '{0, 2'b10, 2'b00, 1, 0, 16'h0,    1, 2'b10, 1, P1,    3'd0, 2'b00, 16'h0,    0};
        tbl[7]  = '{0, 2'b00, 2'b00, 0, 1, 16'hBEEF, 0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0,    1};
        tbl[8]  = '{0, 2'b00, 2'b00, 0, 0, 16'h0,    0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0,    1};
        tbl[9]  = '{0, 2'b01, 2'b01, 1, 0, 16'h0,    1, 2'b01, 1, P0,    3'd1, 2'b00, 16'h0,    1};
        tbl[10] = '{0, 2'b10, 2'b10, 1, 0, 16'h0,    1, 2'b10, 1, P1,    3'd2, 2'b00, 16'h0,    1};
        tbl[11] = '{0, 2'b01, 2'b01, 1, 0, 16'h0,    1, 2'b01, 1, P0,    3'd3, 2'b00, 16'h0,    1};
        tbl[12] = '{0, 2'b00, 2'b00, 0, 1, 16'hAAAA, 0, 2'b00, 0, 20'h0, 3'd2, 2'b01, 16'hAAAA, 1};
        tbl[13] = '{0, 2'b00, 2'b00, 0, 0, 16'h0,    0, 2'b00, 0, 20'h0, 3'd2, 2'b00, 16'hAAAA, 1};
        tbl[14] = '{0, 2'b00, 2'b00, 0, 1, 16'h5555, 0, 2'b00, 0, 20'h0, 3'd1, 2'b10, 16'h5555, 1};
        tbl[15] = '{0, 2'b00, 2'b00, 0, 1, 16'h1234, 0, 2'b00, 0, 20'h0, 3'd0, 2'b01, 16'h1234, 1};
        tbl[16] = '{0, 2'b00, 2'b00, 0, 0, 16'h0,    0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h1234, 1};

        do_reset();
        foreach (tbl[i]) apply(tbl[i]);

        // Read cap: four reads from requester 1, then its fifth waits behind writes.
        do_reset();
        for (int k = 1; k <= 4; k++)
            apply(vec_t'{0, 2'b10, 2'b10, 1, 0, 16'h0, 1, 2'b10, 1, P1, 3'(k), 2'b00, 16'h0, 0});
        for (int k = 0; k < 2; k++)
            apply(vec_t'{0, 2'b11, 2'b10, 1, 0, 16'h0, 1, 2'b01, 1, P0, 3'd4, 2'b00, 16'h0, 0});
        apply(vec_t'{0, 2'b10, 2'b10, 1, 1, 16'h0001, 0, 2'b00, 0, 20'h0, 3'd3, 2'b10, 16'h0001, 0});
        apply(vec_t'{0, 2'b10, 2'b10, 1, 0, 16'h0,    1, 2'b10, 1, P1,    3'd4, 2'b00, 16'h0001, 0});

        // Tag order across pointer wrap with mixed requesters and push+pop cycles.
        do_reset();
        for (int k = 1; k <= 4; k++)
            apply(vec_t'{0, 2'b11, 2'b11, 1, 0, 16'h0, 1, (k % 2 == 1) ? 2'b01 : 2'b10, 1,
                         (k % 2 == 1) ? P0 : P1, 3'(k), 2'b00, 16'h0, 0});
        apply(vec_t'{0, 2'b01, 2'b01, 1, 1, 16'h0101, 0, 2'b00, 0, 20'h0, 3'd3, 2'b01, 16'h0101, 0});
        apply(vec_t'{0, 2'b10, 2'b10, 1, 1, 16'h0202, 1, 2'b10, 1, P1,    3'd3, 2'b10, 16'h0202, 0});
        apply(vec_t'{0, 2'b01, 2'b01, 1, 0, 16'h0,    1, 2'b01, 1, P0,    3'd4, 2'b00, 16'h0202, 0});
        apply(vec_t'{0, 2'b01, 2'b01, 1, 1, 16'h0303, 0, 2'b00, 0, 20'h0, 3'd3, 2'b01, 16'h0303, 0});
        apply(vec_t'{0, 2'b00, 2'b00, 0, 1, 16'h0404, 0, 2'b00, 0, 20'h0, 3'd2, 2'b10, 16'h0404, 0});
        apply(vec_t'{0, 2'b00, 2'b00, 0, 1, 16'h0505, 0, 2'b00, 0, 20'h0, 3'd1, 2'b10, 16'h0505, 0});
        apply(vec_t'{0, 2'b00, 2'b00, 0, 1, 16'h0606, 0, 2'b00, 0, 20'h0, 3'd0, 2'b01, 16'h0606, 0});
        apply(vec_t'{0, 2'b00, 2'b00, 0, 1, 16'h0707, 0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0606, 1});

        // Reset with reads in flight drops their tags; a late response is unexpected.
        do_reset();
        for (int k = 1; k <= 3; k++)
            apply(vec_t'{0, 2'b01, 2'b01, 1, 0, 16'h0, 1, 2'b01, 1, P0, 3'(k), 2'b00, 16'h0, 0});
        apply(vec_t'{1, 2'b01, 2'b01, 1, 0, 16'h0,    0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0, 0});
        apply(vec_t'{0, 2'b00, 2'b00, 0, 1, 16'h9999, 0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0, 1});
        apply(vec_t'{0, 2'b00, 2'b00, 0, 0, 16'h0,    0, 2'b00, 0, 20'h0, 3'd0, 2'b00, 16'h0, 1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
